uart_msg_ctrl: RTL and testbench
================================

UART_MSG_CTRL -- requirements
Module: uart_msg_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: byte width of rxdata/txdata.
REQ-002 Parameter MSG_LEN, default 20: message length in bytes; legal range >=1.
REQ-003 Parameter GAP_CYCLES, default 255: minimum cycles from each wrsig to the next wrsig issue; legal range >=1.
REQ-004 Parameter IDLE_CYCLES, default 16384: rx-silent cycles before an automatic message; legal range >=2.
REQ-005 clk  in  1  uart sampling clock; one clock, all logic on its rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 rdsig  in  1  receive-complete strobe, one cycle per received byte.
REQ-008 rxdata  in  DATA_W  received byte; valid while rdsig=1.
REQ-009 tx_busy  in  1  transmitter busy; a byte is issued only while this is 0.
REQ-010 echo_en  in  1  enables echo of received bytes.
REQ-011 msg_en  in  1  enables the idle-timeout message.
REQ-012 msg_req  in  1  one-cycle request to send the message now.
REQ-013 wrsig  out  1  send request; registered one-cycle pulse.
REQ-014 txdata  out  DATA_W  byte to send; registered; holds its value between pulses.
REQ-015 busy  out  1  high whenever the message FSM is not in IDLE.
REQ-016 msg_done  out  1  one-cycle pulse when the last message byte's gap completes.
REQ-017 echo_ovf  out  1  one-cycle pulse when a pending echo byte is overwritten.

Function
REQ-018 Message FSM states: IDLE, SEND, GAP, DONE; all other encodings return to IDLE on the next cycle.
REQ-019 Echo buffer: one entry. rdsig=1 with echo_en=1 loads rxdata and sets the pending flag; rdsig=1 with echo_en=0 is not captured.
REQ-020 Echo issue: pending flag set, tx_busy=0, gap counter 0 -> wrsig=1 and txdata=buffer on the next edge; pending clears; echo latency is 1 cycle after rdsig when tx_busy is 0.
REQ-021 rdsig while the pending flag is set and the byte is not issued in that cycle -> buffer overwritten with the new byte and echo_ovf pulses.
REQ-022 Echo takes priority over the message byte when both are eligible in the same cycle.
REQ-023 Idle timer: width $clog2(IDLE_CYCLES).
REQ-024 Idle timer increments each cycle the FSM is in IDLE with no echo pending.
REQ-025 Idle timer clears on rdsig, on message start and on DONE.
REQ-026 When msg_en=0, the idle timer wraps to 0 at IDLE_CYCLES-1 without starting a message.
REQ-027 Message start: in IDLE, msg_req=1, or the idle timer reaching IDLE_CYCLES-1 with msg_en=1 -> SEND with index k=0.
REQ-028 msg_req outside IDLE is ignored.
REQ-029 SEND: when tx_busy=0, no echo is eligible and the gap counter is 0, issue byte rom[k] (wrsig pulse) and go to GAP.
REQ-030 GAP: the gap counter loads GAP_CYCLES-1 on each wrsig (echo or message) and decrements to 0.
REQ-031 GAP exit at counter 0: if k<MSG_LEN-1 then k+1 and go to SEND; otherwise go to DONE.
REQ-032 DONE: lasts one cycle, pulses msg_done, then returns to IDLE.
REQ-033 Abort: rdsig with echo_en=1 in SEND or GAP -> IDLE and k=0 on the next edge; no msg_done; the echo proceeds per REQ-020.
REQ-034 rdsig with echo_en=0 does not disturb the message.
REQ-035 Simultaneous msg_req and rdsig in IDLE: rdsig wins, the idle timer clears and no message starts.
REQ-036 k width is $clog2(MSG_LEN) (min 1); k never exceeds MSG_LEN-1.

Reset
REQ-037 rst=1 at any edge, mid-message included -> state IDLE, k=0, all counters 0, pending flag 0, wrsig=0, txdata=0, busy=0, msg_done=0, echo_ovf=0.
REQ-038 rst=1 overrides rdsig and msg_req in the same cycle.

Structure
REQ-039 Package uart_ctrl_pkg holds the state encodings, DEFAULT_DATA_W, and the default message constant "Hello ALINX AX309 " plus 0x0A, 0x0D (20 bytes).
REQ-040 Sub-module uart_msg_rom: combinational lookup, index k -> byte, content taken from the package constant, sized by MSG_LEN.

Verification (MSG_LEN=4, GAP_CYCLES=3, IDLE_CYCLES=16, ROM "Hell")
REQ-041 echo_en=1, tx_busy=0, rdsig with rxdata 0x41 at cycle N -> wrsig=1 and txdata=0x41 at N+1, no other wrsig.
REQ-042 msg_en=1, no rx -> start at idle timer 15; four wrsig pulses 0x48, 0x65, 0x6C, 0x6C, each >=3 cycles apart; msg_done once; busy low afterwards.
REQ-043 tx_busy=1 for 10 cycles during SEND -> no wrsig while busy; the byte is issued 1 cycle after tx_busy falls; no byte lost or repeated.
REQ-044 rdsig 0x5A with echo_en=1 during GAP after byte 2 -> 0x5A echoed; no msg_done; the next message restarts at 0x48.
REQ-045 tx_busy=1, rdsig 0x31 then 0x32 -> echo_ovf pulses once; after tx_busy falls only 0x32 is sent.
REQ-046 rst pulse during the GAP of byte 3 -> all outputs 0 the next cycle; a subsequent msg_req sends the full 4-byte message from 0x48.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_ctrl_pkg : shared types and constants for the UART msg control  |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package uart_ctrl_pkg;

  localparam int DEFAULT_DATA_W  = 8;
  localparam int DEFAULT_MSG_LEN = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } msg_state_t;

  // First character sits in the most significant byte.
  localparam logic [8*DEFAULT_MSG_LEN-1:0] DEFAULT_MSG =
    {"Hello ALINX AX309 ", 8'h0A, 8'h0D};

  function automatic logic [7:0] msg_byte(input int idx);
    logic [7:0] b;
    b = 8'h00;
    if (idx >= 0 && idx < DEFAULT_MSG_LEN)
      b = DEFAULT_MSG[8*(DEFAULT_MSG_LEN-1-idx) +: 8];
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_msg_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_msg_ctrl_if : byte-level rx/tx handshake between UART and ctrl  |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
interface uart_msg_ctrl_if
  import uart_ctrl_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  logic              rdsig;
  logic [DATA_W-1:0] rxdata;
  logic              tx_busy;
  logic              wrsig;
  logic [DATA_W-1:0] txdata;

  modport master (
    input  rdsig,
    input  rxdata,
    input  tx_busy,
    output wrsig,
    output txdata
  );

  modport slave (
    output rdsig,
    output rxdata,
    output tx_busy,
    input  wrsig,
    input  txdata
  );

endinterface
`default_nettype wire

// File: rtl/uart_msg_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_msg_rom : combinational message byte lookup by index            |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module uart_msg_rom
  import uart_ctrl_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int MSG_LEN = DEFAULT_MSG_LEN,
  parameter int IDX_W   = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic [IDX_W-1:0]  i_idx,
  output logic [DATA_W-1:0] o_data
);

  localparam int c_DEPTH = 2**IDX_W;

  logic [DATA_W-1:0] w_rom [c_DEPTH];

  // Entries past the message are unreachable but keep the index fully decoded.
  for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_rom
    assign w_rom[gi] = (gi < MSG_LEN) ? DATA_W'(msg_byte(gi)) : '0;
  end

  assign o_data = w_rom[i_idx];

endmodule
`default_nettype wire

// File: rtl/uart_msg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_msg_ctrl : rx echo plus periodic/requested canned message tx    |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module uart_msg_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int MSG_LEN     = DEFAULT_MSG_LEN,
  parameter int GAP_CYCLES  = 255,
  parameter int IDLE_CYCLES = 16384
) (
  input  logic            clk,
  input  logic            rst,
  uart_msg_ctrl_if.master bus,
  input  logic            echo_en,
  input  logic            msg_en,
  input  logic            msg_req,
  output logic            busy,
  output logic            msg_done,
  output logic            echo_ovf
);

  localparam int c_K_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int c_G_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int c_I_W = $clog2(IDLE_CYCLES);

  localparam logic [c_K_W-1:0] c_K_LAST    = c_K_W'(MSG_LEN - 1);
  localparam logic [c_G_W-1:0] c_GAP_LOAD  = c_G_W'(GAP_CYCLES - 1);
  localparam logic [c_I_W-1:0] c_IDLE_LAST = c_I_W'(IDLE_CYCLES - 1);

  msg_state_t        r_state;
  logic [c_K_W-1:0]  r_k;
  logic [c_G_W-1:0]  r_gap_cnt;
  logic [c_I_W-1:0]  r_idle_cnt;
  logic              r_pend;
  logic [DATA_W-1:0] r_buf;
  logic              r_wrsig;
  logic [DATA_W-1:0] r_txdata;
  logic              r_msg_done;
  logic              r_echo_ovf;

  logic              w_gap_zero;
  logic              w_rx_cap;
  logic              w_echo_go;
  logic              w_abort;
  logic              w_msg_go;
  logic              w_issue;
  logic              w_start;
  logic [DATA_W-1:0] w_rom_byte;

  uart_msg_rom #(
    .DATA_W  (DATA_W),
    .MSG_LEN (MSG_LEN),
    .IDX_W   (c_K_W)
  ) u_rom (
    .i_idx  (r_k),
    .o_data (w_rom_byte)
  );

  assign w_gap_zero = (r_gap_cnt == '0);
  assign w_rx_cap   = bus.rdsig & echo_en;
  assign w_echo_go  = r_pend & ~bus.tx_busy & w_gap_zero;
  assign w_abort    = w_rx_cap & ((r_state == ST_SEND) | (r_state == ST_GAP));
  // A pending echo always wins the slot, so the message byte waits for it.
  assign w_msg_go   = (r_state == ST_SEND) & ~w_abort & ~bus.tx_busy &
                      w_gap_zero & ~r_pend;
  assign w_issue    = w_echo_go | w_msg_go;
  assign w_start    = (r_state == ST_IDLE) & ~bus.rdsig &
                      (msg_req | ((r_idle_cnt == c_IDLE_LAST) & msg_en));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_gap_cnt  <= '0;
      r_idle_cnt <= '0;
      r_pend     <= 1'b0;
      r_buf      <= '0;
      r_wrsig    <= 1'b0;
      r_txdata   <= '0;
      r_msg_done <= 1'b0;
      r_echo_ovf <= 1'b0;
    end else begin
      r_wrsig    <= w_issue;
      r_msg_done <= 1'b0;
      r_echo_ovf <= w_rx_cap & r_pend & ~w_echo_go;

      if (w_echo_go)
        r_txdata <= r_buf;
      else if (w_msg_go)
        r_txdata <= w_rom_byte;

      if (w_rx_cap) begin
        r_buf  <= bus.rxdata;
        r_pend <= 1'b1;
      end else if (w_echo_go) begin
        r_pend <= 1'b0;
      end

      if (w_issue)
        r_gap_cnt <= c_GAP_LOAD;
      else if (!w_gap_zero)
        r_gap_cnt <= r_gap_cnt - c_G_W'(1);

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_SEND;
            r_k     <= '0;
          end
        end
        ST_SEND: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
          end else if (w_msg_go) begin
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
          end else if (w_gap_zero) begin
            if (r_k != c_K_LAST) begin
              r_k     <= r_k + c_K_W'(1);
              r_state <= ST_SEND;
            end else begin
              r_state    <= ST_DONE;
              r_msg_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_k     <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_k     <= '0;
        end
      endcase

      // With msg_en low the timer simply wraps instead of starting a message.
      if (bus.rdsig || w_start || (r_state == ST_DONE))
        r_idle_cnt <= '0;
      else if ((r_state == ST_IDLE) && !r_pend)
        r_idle_cnt <= (r_idle_cnt == c_IDLE_LAST) ? '0 : r_idle_cnt + c_I_W'(1);
    end
  end

  assign bus.wrsig  = r_wrsig;
  assign bus.txdata = r_txdata;
  assign busy       = (r_state != ST_IDLE);
  assign msg_done   = r_msg_done;
  assign echo_ovf   = r_echo_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_msg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_msg_ctrl : self-checking bench for uart_msg_ctrl              |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_uart_msg_ctrl;

  localparam int DW   = 8;
  localparam int ML   = 4;
  localparam int GAP  = 3;
  localparam int IDLE = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic echo_en = 1'b0;
  logic msg_en  = 1'b0;
  logic msg_req = 1'b0;
  logic busy;
  logic msg_done;
  logic echo_ovf;

  uart_msg_ctrl_if #(.DATA_W(DW)) bus ();

  uart_msg_ctrl #(
    .DATA_W      (DW),
    .MSG_LEN     (ML),
    .GAP_CYCLES  (GAP),
    .IDLE_CYCLES (IDLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .echo_en  (echo_en),
    .msg_en   (msg_en),
    .msg_req  (msg_req),
    .busy     (busy),
    .msg_done (msg_done),
    .echo_ovf (echo_ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] hello [ML] = '{8'h48, 8'h65, 8'h6C, 8'h6C};

  int         cyc;
  logic [7:0] wr_q [$];
  int         wr_t [$];
  int         done_cnt;
  int         ovf_cnt;
  int         wr_busy_cnt;

  task automatic tick();
    logic busy_in;
    busy_in = bus.tx_busy;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.wrsig === 1'b1) begin
      wr_q.push_back(bus.txdata);
      wr_t.push_back(cyc);
      if (busy_in) wr_busy_cnt++;
    end
    if (msg_done === 1'b1) done_cnt++;
    if (echo_ovf === 1'b1) ovf_cnt++;
  endtask

  task automatic clear_log();
    cyc = 0;
    wr_q.delete();
    wr_t.delete();
    done_cnt    = 0;
    ovf_cnt     = 0;
    wr_busy_cnt = 0;
  endtask

  task automatic idle_inputs();
    bus.rdsig   = 1'b0;
    bus.rxdata  = '0;
    bus.tx_busy = 1'b0;
    echo_en     = 1'b0;
    msg_en      = 1'b0;
    msg_req     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic pulse_req();
    msg_req = 1'b1;
    tick();
    msg_req = 1'b0;
  endtask

  task automatic run_until_done(input int max_cyc);
    for (int i = 0; i < max_cyc && done_cnt == 0; i++) tick();
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.rdsig = 1'b1; bus.rxdata = 8'hA5; echo_en = 1'b1; msg_req = 1'b1;
    tick();
    total++; if (bus.wrsig !== 1'b0) begin bad++; $display("FAIL reset_wrsig got=%b want=0", bus.wrsig); end
    total++; if (bus.txdata !== 8'h00) begin bad++; $display("FAIL reset_txdata got=%h want=00", bus.txdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (msg_done !== 1'b0 || echo_ovf !== 1'b0) begin
      bad++; $display("FAIL reset_pulses got=%b%b want=00", msg_done, echo_ovf); end
    idle_inputs();
    rst = 1'b0;
    clear_log();
    tick();
    tick();
    total++; if (wr_q.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_override got wr=%0d busy=%b want wr=0 busy=0", wr_q.size(), busy); end
  endtask

  task automatic test_echo_basic();
    do_reset();
    echo_en = 1'b1;
    bus.rdsig = 1'b1; bus.rxdata = 8'h41;
    tick();
    bus.rdsig = 1'b0;
    total++; if (bus.wrsig !== 1'b0) begin bad++; $display("FAIL echo_early got=%b want=0", bus.wrsig); end
    tick();
    total++; if (bus.wrsig !== 1'b1 || bus.txdata !== 8'h41) begin
      bad++; $display("FAIL echo_issue got wr=%b tx=%h want wr=1 tx=41", bus.wrsig, bus.txdata); end
    repeat (10) tick();
    total++; if (wr_q.size() != 1) begin bad++; $display("FAIL echo_count got=%0d want=1", wr_q.size()); end
  endtask

  task automatic test_idle_msg();
    int busy_first;
    busy_first = -1;
    do_reset();
    msg_en = 1'b1;
    for (int i = 0; i < 200 && done_cnt == 0; i++) begin
      tick();
      if (busy === 1'b1 && busy_first < 0) busy_first = cyc;
    end
    tick();
    msg_en = 1'b0;
    total++; if (busy_first != IDLE) begin bad++; $display("FAIL idle_start got=%0d want=%0d", busy_first, IDLE); end
    total++; if (wr_q.size() != ML) begin bad++; $display("FAIL idle_len got=%0d want=%0d", wr_q.size(), ML); end
    for (int i = 0; i < ML && i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== hello[i]) begin bad++; $display("FAIL idle_byte%0d got=%h want=%h", i, wr_q[i], hello[i]); end
      if (i > 0) begin
        total++; if (wr_t[i] - wr_t[i-1] < GAP) begin
          bad++; $display("FAIL idle_gap%0d got=%0d want>=%0d", i, wr_t[i] - wr_t[i-1], GAP); end
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL idle_done got=%0d want=1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_busy_stall();
    do_reset();
    bus.tx_busy = 1'b1;
    pulse_req();
    repeat (10) tick();
    total++; if (wr_q.size() != 0) begin bad++; $display("FAIL stall_wr got=%0d want=0", wr_q.size()); end
    bus.tx_busy = 1'b0;
    tick();
    total++; if (bus.wrsig !== 1'b1 || bus.txdata !== 8'h48) begin
      bad++; $display("FAIL stall_release got wr=%b tx=%h want wr=1 tx=48", bus.wrsig, bus.txdata); end
    // Random busy and stray requests while the message is in flight.
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      bus.tx_busy = ($urandom_range(0, 2) == 0);
      msg_req     = (busy === 1'b1 && done_cnt == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    msg_req = 1'b0;
    bus.tx_busy = 1'b0;
    repeat (30) tick();
    total++; if (wr_q.size() != ML) begin bad++; $display("FAIL stall_len got=%0d want=%0d", wr_q.size(), ML); end
    for (int i = 0; i < ML && i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== hello[i]) begin bad++; $display("FAIL stall_byte%0d got=%h want=%h", i, wr_q[i], hello[i]); end
    end
    total++; if (wr_busy_cnt != 0) begin bad++; $display("FAIL stall_wr_while_busy got=%0d want=0", wr_busy_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL stall_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_abort();
    do_reset();
    pulse_req();
    for (int i = 0; i < 60 && wr_q.size() < 2; i++) tick();
    total++; if (wr_q.size() != 2) begin bad++; $display("FAIL abort_setup got=%0d want=2", wr_q.size()); end
    echo_en = 1'b1;
    bus.rdsig = 1'b1; bus.rxdata = 8'h5A;
    tick();
    bus.rdsig = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    repeat (40) tick();
    total++; if (wr_q.size() != 3) begin bad++; $display("FAIL abort_count got=%0d want=3", wr_q.size()); end
    else begin
      total++; if (wr_q[2] !== 8'h5A) begin bad++; $display("FAIL abort_echo got=%h want=5A", wr_q[2]); end
    end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_done got=%0d want=0", done_cnt); end
    clear_log();
    pulse_req();
    run_until_done(100);
    total++; if (wr_q.size() != ML) begin bad++; $display("FAIL abort_restart_len got=%0d want=%0d", wr_q.size(), ML); end
    for (int i = 0; i < ML && i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== hello[i]) begin bad++; $display("FAIL abort_restart%0d got=%h want=%h", i, wr_q[i], hello[i]); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    echo_en = 1'b1;
    bus.tx_busy = 1'b1;
    bus.rdsig = 1'b1; bus.rxdata = 8'h31;
    tick();
    total++; if (echo_ovf !== 1'b0) begin bad++; $display("FAIL ovf_first got=%b want=0", echo_ovf); end
    bus.rxdata = 8'h32;
    tick();
    bus.rdsig = 1'b0;
    total++; if (echo_ovf !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b want=1", echo_ovf); end
    repeat (5) tick();
    total++; if (ovf_cnt != 1 || wr_q.size() != 0) begin
      bad++; $display("FAIL ovf_hold got ovf=%0d wr=%0d want ovf=1 wr=0", ovf_cnt, wr_q.size()); end
    bus.tx_busy = 1'b0;
    tick();
    total++; if (bus.wrsig !== 1'b1 || bus.txdata !== 8'h32) begin
      bad++; $display("FAIL ovf_send got wr=%b tx=%h want wr=1 tx=32", bus.wrsig, bus.txdata); end
    repeat (10) tick();
    total++; if (wr_q.size() != 1) begin bad++; $display("FAIL ovf_count got=%0d want=1", wr_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_req();
    for (int i = 0; i < 60 && wr_q.size() < 3; i++) tick();
    total++; if (wr_q.size() != 3) begin bad++; $display("FAIL rmid_setup got=%0d want=3", wr_q.size()); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bus.wrsig !== 1'b0 || bus.txdata !== 8'h00 || busy !== 1'b0 ||
                 msg_done !== 1'b0 || echo_ovf !== 1'b0) begin
      bad++; $display("FAIL rmid_outputs got wr=%b tx=%h busy=%b done=%b ovf=%b want all 0",
                      bus.wrsig, bus.txdata, busy, msg_done, echo_ovf); end
    repeat (3) tick();
    clear_log();
    pulse_req();
    run_until_done(100);
    total++; if (wr_q.size() != ML || done_cnt != 1) begin
      bad++; $display("FAIL rmid_len got wr=%0d done=%0d want wr=%0d done=1", wr_q.size(), done_cnt, ML); end
    for (int i = 0; i < ML && i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== hello[i]) begin bad++; $display("FAIL rmid_byte%0d got=%h want=%h", i, wr_q[i], hello[i]); end
    end
  endtask

  // Echo-only traffic against a one-entry buffer model timed by issue timestamps.
  task automatic test_random_echo();
    logic       m_pend;
    logic [7:0] m_buf;
    logic [7:0] m_tx;
    int         last_wr;
    logic       rd, en, tb, elig, exp_ovf;
    logic [7:0] d;
    int         t;
    do_reset();
    m_pend = 1'b0; m_buf = 8'h00; m_tx = 8'h00; last_wr = -1000;
    for (int i = 0; i < 400; i++) begin
      rd = ($urandom_range(0, 2) == 0);
      en = ($urandom_range(0, 4) != 0);
      tb = ($urandom_range(0, 2) == 0);
      d  = 8'($urandom);
      bus.rdsig = rd; echo_en = en; bus.tx_busy = tb; bus.rxdata = d;
      t = cyc + 1;
      elig    = m_pend && !tb && (t - last_wr >= GAP);
      exp_ovf = rd && en && m_pend && !elig;
      if (elig) begin m_tx = m_buf; last_wr = t; m_pend = 1'b0; end
      if (rd && en) begin m_buf = d; m_pend = 1'b1; end
      tick();
      total++; if (bus.wrsig !== elig) begin bad++; $display("FAIL rnd_wrsig@%0d got=%b want=%b", cyc, bus.wrsig, elig); end
      total++; if (bus.txdata !== m_tx) begin bad++; $display("FAIL rnd_txdata@%0d got=%h want=%h", cyc, bus.txdata, m_tx); end
      total++; if (echo_ovf !== exp_ovf) begin bad++; $display("FAIL rnd_ovf@%0d got=%b want=%b", cyc, echo_ovf, exp_ovf); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_busy@%0d got=%b want=0", cyc, busy); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    clear_log();
    test_reset();
    test_echo_basic();
    test_idle_msg();
    test_busy_stall();
    test_abort();
    test_overflow();
    test_reset_mid();
    test_random_echo();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
